// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the seq_divider16 restoring divider.
// Contents: state_t (IDLE, RUN, DONE), DIV_W operand width, CNT_W iteration
// counter width, DIV_ZERO_Q quotient reported for a zero divisor.
package div_pkg;

    localparam int DIV_W = 16;
    localparam int CNT_W = 4;
    localparam logic [DIV_W-1:0] DIV_ZERO_Q = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/csa_sub17.sv
// csa_sub17: combinational 17-bit carry-select subtractor, diff = a - b (mod 2^17).
// Ports: a, b       17-bit unsigned operands
//        diff       17-bit difference computed as a + ~b + 1
//        no_borrow  carry out of the top slice, 1 when a >= b
// Structure: ripple-carry slice for bits [4:0], then three 4-bit slices that
// precompute both carry-in cases and select on the incoming carry.
module csa_sub17 (
    input  logic [16:0] a,
    input  logic [16:0] b,
    output logic [16:0] diff,
    output logic        no_borrow
);

    logic [16:0] bn;
    logic [4:0]  lo_diff;
    logic        lo_carry;
    logic [11:0] hi_diff;
    logic [3:0]  c;

    assign bn = ~b;

    // Carry-in of 1 turns the inverted subtrahend into its two's complement.
    always_comb begin
        lo_carry = 1'b1;
        lo_diff  = '0;
        for (int i = 0; i < 5; i++) begin
            lo_diff[i] = a[i] ^ bn[i] ^ lo_carry;
            lo_carry   = (a[i] & bn[i]) | (lo_carry & (a[i] ^ bn[i]));
        end
    end

    assign c[0] = lo_carry;

    for (genvar s = 0; s < 3; s++) begin : g_sel
        logic [4:0] s0;
        logic [4:0] s1;
        assign s0 = {1'b0, a[5+4*s +: 4]} + {1'b0, bn[5+4*s +: 4]};
        assign s1 = {1'b0, a[5+4*s +: 4]} + {1'b0, bn[5+4*s +: 4]} + 5'd1;
        assign hi_diff[4*s +: 4] = c[s] ? s1[3:0] : s0[3:0];
        assign c[s+1]            = c[s] ? s1[4] : s0[4];
    end

    assign diff      = {hi_diff, lo_diff};
    assign no_borrow = c[3];

endmodule

// File: rtl/seq_divider16.sv
// seq_divider16: iterative 16-bit unsigned restoring divider, one quotient bit per clock.
// Ports: clk, rst (sync, active-high)
//        in_valid/in_ready, dividend, divisor     request handshake, operands sampled on accept
//        out_valid/out_ready, quotient, remainder result handshake, held until taken
//        div_zero                                 only when DIV_ZERO_FLAG_EN is defined
// Option DIV_ZERO_FLAG_EN: a zero divisor skips the iterations, reports
// quotient=0xFFFF, remainder=dividend and raises div_zero while out_valid.
// Only WIDTH=16 is supported; the subtractor is sliced for 17 bits.
module seq_divider16
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic             div_zero
`endif
);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [DIV_W-1:0] q, r, d;
    logic [DIV_W:0]   t;
    logic             no_borrow;
    logic             take;
    logic             accept;
    logic             zero_div;

    assign accept = in_valid && in_ready;

`ifdef DIV_ZERO_FLAG_EN
    assign zero_div = (divisor == '0);
`else
    assign zero_div = 1'b0;
`endif

    // Trial subtraction of the divisor from the partial remainder shifted by the next dividend bit.
    csa_sub17 u_sub (
        .a         ({r, q[DIV_W-1]}),
        .b         ({1'b0, d}),
        .diff      (t),
        .no_borrow (no_borrow)
    );

    // Because R < D always holds, a clear sign bit and a carry out coincide.
    assign take = no_borrow && !t[DIV_W];

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        case (state)
            IDLE:    state_n = accept ? (zero_div ? DONE : RUN) : IDLE;
            RUN:     state_n = (cnt == '0) ? DONE : RUN;
            DONE:    state_n = out_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= '0;
            r   <= '0;
            d   <= '0;
            cnt <= '0;
        end else if (accept) begin
            d   <= divisor;
            cnt <= CNT_W'(DIV_W - 1);
            q   <= zero_div ? DIV_ZERO_Q : dividend;
            r   <= zero_div ? dividend : '0;
        end else if (state == RUN) begin
            q   <= {q[DIV_W-2:0], take};
            r   <= take ? t[DIV_W-1:0] : {r[DIV_W-2:0], q[DIV_W-1]};
            cnt <= (cnt == '0) ? cnt : cnt - 1'b1;
        end
    end

`ifdef DIV_ZERO_FLAG_EN
    always_ff @(posedge clk) begin
        if (rst)
            div_zero <= 1'b0;
        else if (accept)
            div_zero <= zero_div;
        else if (out_valid && out_ready)
            div_zero <= 1'b0;
    end
`endif

    assign quotient  = q;
    assign remainder = r;

endmodule
